hwpe_tcdm_responder: RTL

- Memory-side responder for the HWPE TCDM master protocol: one shared word-addressed SRAM bank behind NB_PORTS TCDM slave ports.
- Arbitrates concurrent requests round-robin and serves one access per cycle with fixed 1-cycle response latency.
- Serves as the bench and FPGA-bring-up target for the TCDM master ports of generated HWPE tops (tcdm[MP-1:0]), replacing the cluster interconnect plus TCDM banks.

---
 rtl/hwpe_tcdm_responder_if.sv | 24 ++
 rtl/hwpe_tcdm_responder.sv | 69 ++++++
 2 files changed

// File: rtl/hwpe_tcdm_responder_if.sv
// hwpe_tcdm_responder_if: bundle of NB_PORTS TCDM request/response channels plus per-port grant mask.
interface hwpe_tcdm_responder_if #(
    parameter int NB_PORTS = 3,
    parameter int AW       = 32
);
    logic [NB_PORTS-1:0]          tcdm_req_i;
    logic [NB_PORTS-1:0]          tcdm_gnt_o;
    logic [NB_PORTS-1:0][AW-1:0]  tcdm_add_i;
    logic [NB_PORTS-1:0]          tcdm_wen_i;
    logic [NB_PORTS-1:0][3:0]     tcdm_be_i;
    logic [NB_PORTS-1:0][31:0]    tcdm_data_i;
    logic [NB_PORTS-1:0][31:0]    tcdm_r_data_o;
    logic [NB_PORTS-1:0]          tcdm_r_valid_o;
    logic [NB_PORTS-1:0]          stall_i;

    modport master (
        output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i, stall_i,
        input  tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
    );
    modport slave (
        input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i, stall_i,
        output tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
    );
endinterface

// File: rtl/hwpe_tcdm_responder.sv
// hwpe_tcdm_responder: single-bank TCDM memory shared round-robin by NB_PORTS ports, 1-cycle response latency.
module hwpe_tcdm_responder #(
    parameter int NB_PORTS = 3,
    parameter int DEPTH    = 1024,
    parameter int AW       = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    hwpe_tcdm_responder_if.slave tcdm
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = NB_PORTS > 1 ? $clog2(NB_PORTS) : 1;

    if (AW < IW + 2) begin : g_aw_chk
        $error("hwpe_tcdm_responder: AW must be at least log2(DEPTH)+2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("hwpe_tcdm_responder: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]             r_ptr;
    logic [PW-1:0]             w_sel;
    logic [NB_PORTS-1:0]       w_elig;
    logic [NB_PORTS-1:0]       w_gnt;
    logic [NB_PORTS-1:0]       r_valid;
    logic [NB_PORTS-1:0][31:0] r_rdata;
    logic [31:0]               r_mem [DEPTH];
    logic                      w_any;
    logic                      w_wen;
    logic [3:0]                w_be;
    logic [31:0]               w_data;
    logic [IW-1:0]             w_idx;

    assign w_elig = tcdm.tcdm_req_i & ~tcdm.stall_i;
    assign w_any  = |w_elig && !rst_i;

    // Lowest eligible port overall is the wrap-around fallback; lowest at/after the pointer overrides it.
    always_comb begin
        w_sel = '0;
        for (int p = NB_PORTS - 1; p >= 0; p--) if (w_elig[p]) w_sel = PW'(p);
        for (int p = NB_PORTS - 1; p >= 0; p--) if (w_elig[p] && PW'(p) >= r_ptr) w_sel = PW'(p);
    end

    assign w_gnt  = w_any ? NB_PORTS'(1) << w_sel : '0;
    assign w_wen  = tcdm.tcdm_wen_i[w_sel];
    assign w_be   = tcdm.tcdm_be_i[w_sel];
    assign w_data = tcdm.tcdm_data_i[w_sel];
    assign w_idx  = tcdm.tcdm_add_i[w_sel][2 +: IW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_valid <= '0;
            r_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_valid <= w_gnt;
            if (w_any) begin
                r_ptr          <= (w_sel == PW'(NB_PORTS - 1)) ? '0 : w_sel + 1'b1;
                r_rdata[w_sel] <= w_wen ? r_mem[w_idx] : '0;
                if (!w_wen) for (int b = 0; b < 4; b++) if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    assign tcdm.tcdm_gnt_o     = w_gnt;
    assign tcdm.tcdm_r_valid_o = r_valid;
    assign tcdm.tcdm_r_data_o  = r_rdata;
endmodule
